// File: rtl/acl_spi_poller_pkg.sv
// Shared constants for the PmodACL (ADXL345) SPI poller: FSM states, register/command bytes, helpers.
// Constants marked for the power-up write are only consumed when ACL_INIT_EN is defined.
package acl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT_WR  = 3'd1,
        CS_SETUP = 3'd2,
        SHIFT    = 3'd3,
        CS_HOLD  = 3'd4,
        DONE     = 3'd5
    } acl_state_e;

    localparam logic [7:0] ACL_RD_MB_DATAX0      = 8'hF2;
    localparam logic [7:0] ACL_REG_POWER_CTL     = 8'h2D;
    localparam logic [7:0] ACL_POWER_CTL_MEASURE = 8'h08;

    // Read burst: 8 command bits then 48 data bits, indexed 0..55.
    localparam logic [5:0] READ_FIRST_DATA_BIT = 6'd8;
    localparam logic [5:0] READ_LAST_BIT       = 6'd55;

    // Power-up write counted in half-periods: 2 setup, 32 clocking, 2 hold.
    localparam logic [5:0] INIT_FIRST_SCLK_HALF = 6'd2;
    localparam logic [5:0] INIT_LAST_SCLK_HALF  = 6'd33;
    localparam logic [5:0] INIT_LAST_HALF       = 6'd35;

    // The ADXL345 sends the low byte of each axis first.
    function automatic logic [15:0] swapBytes(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/acl_spi_poller_if.sv
// Bus between the accelerometer poller, the SPI pins and the pong logic.
// master = poller side, slave = pins / consumer side.
interface acl_spi_poller_if;

    logic        START;
    logic        MISO;
    logic        SS;
    logic        SCLK;
    logic        MOSI;
    logic [15:0] XAXIS;
    logic [15:0] YAXIS;
    logic [15:0] ZAXIS;
    logic        DATA_VALID;
    logic        BUSY;

    modport master (
        input  START, MISO,
        output SS, SCLK, MOSI, XAXIS, YAXIS, ZAXIS, DATA_VALID, BUSY
    );

    modport slave (
        output START, MISO,
        input  SS, SCLK, MOSI, XAXIS, YAXIS, ZAXIS, DATA_VALID, BUSY
    );

endinterface

// File: rtl/acl_spi_poller_sclk_gen.sv
// SCLK generator: half-period counter with fall/rise ticks; SCLK idles high (CPOL=1) when disabled.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic sclk_en_i,
    output logic tick_o,
    output logic fall_tick_o,
    output logic rise_tick_o,
    output logic sclk_o
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;

    assign tick_o      = run_i && (cnt_q == TERM);
    // Ticks fire on the last CLK of a half-period, so SCLK moves on the following edge.
    assign fall_tick_o = tick_o && sclk_en_i && phase_q;
    assign rise_tick_o = tick_o && sclk_en_i && !phase_q;
    assign sclk_o      = !sclk_en_i || phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        if (!sclk_en_i) begin
            phase_d = 1'b0;
        end else if (tick_o) begin
            phase_d = !phase_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/acl_spi_poller.sv
// PmodACL poller: one SPI mode-3 burst read of X/Y/Z per START rising edge, axis words + valid pulse.
// Define ACL_INIT_EN to issue a POWER_CTL measure-mode write after reset before the first read.
module acl_spi_poller
    import acl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50,
    parameter logic [7:0]  RD_CMD  = ACL_RD_MB_DATAX0
) (
    input  logic              CLK,
    input  logic              RST,
    acl_spi_poller_if.master  bus
);

    acl_state_e  state_q, state_d;
    logic        start_q;
    logic        go;
    logic [5:0]  bit_q, bit_d;
    logic [15:0] tx_q, tx_d;
    logic        mosi_q, mosi_d;
    logic [47:0] rx_q, rx_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] z_q, z_d;

    logic run;
    logic sclk_en;
    logic init_sclk;
    logic tick;
    logic fall_tick;
    logic rise_tick;

`ifdef ACL_INIT_EN
    localparam logic [15:0] INIT_WORD = {ACL_REG_POWER_CTL, ACL_POWER_CTL_MEASURE};
    logic init_pend_q, init_pend_d;

    assign init_sclk   = (state_q == INIT_WR) &&
                         (bit_q >= INIT_FIRST_SCLK_HALF) && (bit_q <= INIT_LAST_SCLK_HALF);
    assign init_pend_d = (state_q == IDLE) ? 1'b0 : init_pend_q;
`else
    assign init_sclk = 1'b0;
`endif

    assign go      = bus.START && !start_q;
    assign run     = (state_q == INIT_WR) || (state_q == CS_SETUP) ||
                     (state_q == SHIFT)   || (state_q == CS_HOLD);
    assign sclk_en = (state_q == SHIFT) || init_sclk;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .run_i       (run),
        .sclk_en_i   (sclk_en),
        .tick_o      (tick),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick),
        .sclk_o      (bus.SCLK)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef ACL_INIT_EN
                if (init_pend_q) begin
                    state_d = INIT_WR;
                end else
`endif
                if (go) begin
                    state_d = CS_SETUP;
                end
            end
`ifdef ACL_INIT_EN
            INIT_WR: begin
                if (tick && (bit_q == INIT_LAST_HALF)) begin
                    state_d = IDLE;
                end
            end
`endif
            CS_SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_tick && (bit_q == READ_LAST_BIT)) begin
                    state_d = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.SS         = 1'b1;
        bus.BUSY       = 1'b0;
        bus.DATA_VALID = 1'b0;
        case (state_q)
            INIT_WR, CS_SETUP, SHIFT, CS_HOLD: begin
                bus.SS   = 1'b0;
                bus.BUSY = 1'b1;
            end
            DONE: begin
                bus.BUSY       = 1'b1;
                bus.DATA_VALID = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.MOSI  = mosi_q;
    assign bus.XAXIS = x_q;
    assign bus.YAXIS = y_q;
    assign bus.ZAXIS = z_q;

    // MOSI shifts out of tx on falls; zeros fill behind so MOSI rests at 0 after each word.
    always_comb begin
        bit_d  = bit_q;
        tx_d   = tx_q;
        mosi_d = mosi_q;
        rx_d   = rx_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        case (state_q)
            IDLE: begin
                bit_d = '0;
`ifdef ACL_INIT_EN
                if (init_pend_q) begin
                    tx_d   = INIT_WORD;
                    mosi_d = INIT_WORD[15];
                end else
`endif
                if (go) begin
                    tx_d   = {RD_CMD, 8'h00};
                    mosi_d = RD_CMD[7];
                    rx_d   = '0;
                end
            end
`ifdef ACL_INIT_EN
            INIT_WR: begin
                if (tick) begin
                    bit_d = bit_q + 6'd1;
                end
                if (fall_tick) begin
                    mosi_d = tx_q[14];
                    tx_d   = {tx_q[14:0], 1'b0};
                end
            end
`endif
            SHIFT: begin
                if (fall_tick) begin
                    mosi_d = tx_q[14];
                    tx_d   = {tx_q[14:0], 1'b0};
                    bit_d  = (bit_q == READ_LAST_BIT) ? 6'd0 : bit_q + 6'd1;
                end
                if (rise_tick && (bit_q >= READ_FIRST_DATA_BIT)) begin
                    rx_d = {rx_q[46:0], bus.MISO};
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    x_d = swapBytes(rx_q[47:32]);
                    y_d = swapBytes(rx_q[31:16]);
                    z_d = swapBytes(rx_q[15:0]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            start_q <= 1'b0;
            bit_q   <= '0;
            tx_q    <= '0;
            mosi_q  <= 1'b0;
            rx_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            start_q <= bus.START;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            mosi_q  <= mosi_d;
            rx_q    <= rx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

`ifdef ACL_INIT_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            init_pend_q <= 1'b1;
        end else begin
            init_pend_q <= init_pend_d;
        end
    end
`endif

endmodule

// File: doc/acl_spi_poller.md
Name: acl_spi_poller

Overview:
- Consumes the 5 Hz send/receive strobe from the clock divider and runs one SPI mode-3 burst read of the PmodACL (ADXL345) X/Y/Z data registers per strobe rising edge.
- Assembles the six returned bytes into three 16-bit axis words.
- Hands the words to the pong paddle/ball logic with a one-cycle valid pulse.

Parameters:
- CLK_DIV, 50: SCLK half-period in CLK cycles; 100 MHz CLK gives 1 MHz SCLK. Legal range 2..255.
- RD_CMD, 8'hF2: read + multibyte + address 0x32 (DATAX0).

Ports:
- CLK  in  1  100 MHz onboard clock.
- RST  in  1  synchronous, active-low reset (asserted when 0, sampled on CLK rising edge).
- START  in  1  5 Hz strobe from the clock divider; level signal, rising edge triggers a read.
- MISO  in  1  from accelerometer.
- SS  out  1  chip select, active-low.
- SCLK  out  1  SPI clock, idles high (CPOL=1).
- MOSI  out  1  SPI data out, MSB first.
- XAXIS  out  16  {DATAX1,DATAX0}.
- YAXIS  out  16  {DATAY1,DATAY0}.
- ZAXIS  out  16  {DATAZ1,DATAZ0}.
- DATA_VALID  out  1  one-cycle pulse when all axis outputs update together.
- BUSY  out  1  high from SS fall through the DONE cycle.

Behaviour:
- Reset values (RST=0 at a CLK edge):
  - SS=1, SCLK=1, MOSI=0, XAXIS/YAXIS/ZAXIS=0, DATA_VALID=0, BUSY=0.
  - start_q=0, state=IDLE, all counters 0.
  - Reset mid-transaction aborts immediately. The partial shift register is discarded and the axis outputs are cleared.
- Edge detect:
  - start_q registers START.
  - go = START & ~start_q.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> DONE -> IDLE.
- IDLE:
  - SS=1, SCLK=1.
  - On go: enter CS_SETUP next cycle. SS drops on that same edge; BUSY=1.
- CS_SETUP:
  - SS=0, SCLK=1 for CLK_DIV cycles.
  - MOSI presents RD_CMD[7].
- SHIFT:
  - 56 SCLK periods: 8 command bits, then 48 read bits.
  - SCLK falls for CLK_DIV cycles, then rises for CLK_DIV cycles.
  - MOSI updates on each SCLK falling edge, MSB first. It is 0 after the command byte.
  - MISO is sampled into a 48-bit shift register on each SCLK rising edge, only for bits 8..55.
- CS_HOLD:
  - SCLK=1, SS=0 for CLK_DIV cycles.
  - Then SS returns to 1.
- DONE (one cycle):
  - Byte order received is X0,X1,Y0,Y1,Z0,Z1.
  - XAXIS={X1,X0}, YAXIS={Y1,Y0}, ZAXIS={Z1,Z0}.
  - DATA_VALID=1, BUSY=1. Next state is IDLE.
- Total SS-low time is 114*CLK_DIV CLK cycles (5700 at default). DATA_VALID pulses on the cycle SS returns high.
- A go edge outside IDLE is dropped, with no queuing. START held high does not retrigger.
- Bit counter is 6 bits, terminal value 55. Half-period counter is 8 bits, terminal value CLK_DIV-1, then wraps to 0.
- Outputs hold their last values between transactions.

Optional Feature:
- Macro: ACL_INIT_EN.
- Defined:
  - After reset release, the state machine enters INIT_WR before IDLE.
  - INIT_WR performs one 16-bit write {8'h2D, 8'h08} (POWER_CTL measure mode) with the same SS/SCLK timing: 2*CLK_DIV setup/hold, 16 SCLK periods.
  - BUSY=1 throughout. No DATA_VALID pulse.
  - START edges during INIT_WR are dropped.
- Undefined:
  - Reset goes directly to IDLE.
  - The device is configured by other logic.

Decomposition:
- Package acl_pkg:
  - State encoding constants: IDLE, INIT_WR, CS_SETUP, SHIFT, CS_HOLD, DONE.
  - Register/command constants: ACL_RD_MB_DATAX0=8'hF2, ACL_REG_POWER_CTL=8'h2D, ACL_POWER_CTL_MEASURE=8'h08.
- Sub-module spi_sclk_gen:
  - Half-period counter.
  - Emits fall_tick/rise_tick and drives SCLK while enabled; SCLK is high when disabled.
- The shift/sequence FSM stays in acl_spi_poller.

Test Plan:
- Reset then idle: RST=0 for 3 cycles, START=0 -> SS=1, SCLK=1, all axis outputs 0, DATA_VALID never asserts.
- Single read: MISO model returns 34,12,78,56,BC,9A hex; START rises -> MOSI byte captured = F2, SS low exactly 5700 cycles, XAXIS=1234h, YAXIS=5678h, ZAXIS=9ABCh, DATA_VALID high exactly 1 cycle.
- Retrigger while busy: a second START rising edge 1000 cycles into a read -> only one transaction and one DATA_VALID. START held high for 20M cycles -> one transaction only.
- Reset mid-transfer: RST=0 at cycle 3000 of SHIFT -> next edge SS=1, SCLK=1, axis outputs 0, no DATA_VALID. A new START works normally afterwards.
- Back-to-back: START toggled at 10 ms period with CLK_DIV=2 -> every edge produces a read. SS deasserts between reads for at least 1 cycle.
- ACL_INIT_EN defined: release reset -> 16-bit MOSI word 2D08h seen with SS low for 36*CLK_DIV cycles before any START-triggered read. A START during it is ignored.
